dds_wavegen: RTL

Parametrised, double-buffered DDS waveform generator driving a parallel DAC. It is the next-generation arbitrary-waveform engine: configurable phase, table and sample widths; phase offset; unity-capable amplitude scaling with signed DC offset and saturation; glitch-free table swap at a period boundary; continuous or triggered burst mode; and a registered DAC strobe instead of a gated clock. It sits between the register bank (configuration and table writes) and the DAC pins.

---
 rtl/dds_wavegen.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/dds_wavegen.sv
`default_nettype none
// ============================================================================
// Module   : dds_wavegen
// Brief    : Double-buffered DDS waveform generator with amplitude scaling,
//            signed DC offset, saturation, burst mode and a registered DAC strobe.
// Revision : 1.0 - initial release
// ============================================================================
module dds_wavegen #(
    parameter int PHASE_W = 32,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int AMP_W   = 8,
    parameter int BURST_W = 16,
    parameter int CLK_DIV = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic               mode,
    input  logic [PHASE_W-1:0] freq_word,
    input  logic [PHASE_W-1:0] phase_offset,
    input  logic [AMP_W-1:0]   amplitude,
    input  logic [DATA_W:0]    dc_offset,
    input  logic [BURST_W-1:0] burst_cycles,
    input  logic               trigger,
    input  logic               wr_en,
    input  logic [DATA_W-1:0]  wr_data,
    input  logic               wr_ptr_clr,
    input  logic               swap_req,
    output logic               dac_clk,
    output logic [DATA_W-1:0]  dac_out,
    output logic               bank_ready,
    output logic               active_bank,
    output logic               busy,
    output logic               burst_done
);

    localparam int c_DEPTH = 1 << ADDR_W;
    localparam int c_DIV_W = $clog2(CLK_DIV);
    localparam int c_HALF  = CLK_DIV / 2;
    localparam int c_STB_W = $clog2(c_HALF + 1);

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_RUN_CONT  = 2'd1;
    localparam logic [1:0] c_RUN_BURST = 2'd2;

    localparam logic [BURST_W-1:0] c_BURST_ONE = BURST_W'(1);
    localparam logic [DATA_W-1:0]  c_DATA_MAX  = {DATA_W{1'b1}};

    logic [DATA_W-1:0]  r_mem [0:2*c_DEPTH-1];

    logic [1:0]         r_state;
    logic [PHASE_W-1:0] r_acc;
    logic [c_DIV_W-1:0] r_div;
    logic [BURST_W-1:0] r_burst_cnt;
    logic [ADDR_W-1:0]  r_wr_ptr;
    logic               r_bank_ready;
    logic               r_active;
    logic               r_pending;
    logic               r_table_valid;
    logic               r_trig_d;
    logic               r_v1;
    logic               r_v2;
    logic [DATA_W-1:0]  r_rd_data;
    logic [DATA_W-1:0]  r_scaled;
    logic [DATA_W-1:0]  r_dac_out;
    logic               r_dac_clk;
    logic [c_STB_W-1:0] r_stb_cnt;
    logic               r_burst_done;

    logic                      w_running;
    logic                      w_tick;
    logic [PHASE_W-1:0]        w_phase;
    logic [ADDR_W-1:0]         w_addr;
    logic [PHASE_W:0]          w_acc_sum;
    logic                      w_wrap_tick;
    logic                      w_trig_rise;
    logic                      w_burst_last;
    logic                      w_abort;
    logic                      w_swap_now;
    logic                      w_wr_ok;
    logic [DATA_W+AMP_W-1:0]   w_prod;
    logic [DATA_W-1:0]         w_scaled;
    logic signed [DATA_W+1:0]  w_sum;
    logic [DATA_W-1:0]         w_sat;

    assign w_running   = (r_state != c_IDLE);
    assign w_tick      = w_running && (r_div == '0);
    assign w_phase     = r_acc + phase_offset;
    assign w_addr      = ADDR_W'(w_phase >> (PHASE_W - ADDR_W));
    assign w_acc_sum   = {1'b0, r_acc} + {1'b0, freq_word};
    assign w_wrap_tick = w_tick && w_acc_sum[PHASE_W];
    assign w_trig_rise = trigger && !r_trig_d;
    assign w_burst_last = (r_state == c_RUN_BURST) && w_wrap_tick &&
                          (r_burst_cnt == burst_cycles - c_BURST_ONE);
    assign w_abort     = w_running && (!enable ||
                         ((r_state == c_RUN_CONT) && mode) ||
                         ((r_state == c_RUN_BURST) && !mode));
    // Running swaps wait for the period boundary so every period comes from one bank.
    assign w_swap_now  = r_pending && ((r_state == c_IDLE) || w_wrap_tick);
    assign w_wr_ok     = wr_en && !wr_ptr_clr && !r_pending;

    assign w_prod   = (DATA_W+AMP_W)'(r_rd_data) * (DATA_W+AMP_W)'(amplitude);
    assign w_scaled = (&amplitude) ? r_rd_data : DATA_W'(w_prod >> AMP_W);
    assign w_sum    = $signed({2'b00, r_scaled}) + $signed({dc_offset[DATA_W], dc_offset});

    always_comb begin
        w_sat = w_sum[DATA_W-1:0];
        if (w_sum < 0) begin
            w_sat = '0;
        end else if (w_sum[DATA_W]) begin
            w_sat = c_DATA_MAX;
        end
    end

    // Table storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[{~r_active, r_wr_ptr}] <= wr_data;
        end
        if (w_tick) begin
            r_rd_data <= r_mem[{r_active, w_addr}];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_IDLE;
            r_acc         <= '0;
            r_div         <= '0;
            r_burst_cnt   <= '0;
            r_wr_ptr      <= '0;
            r_bank_ready  <= 1'b0;
            r_active      <= 1'b0;
            r_pending     <= 1'b0;
            r_table_valid <= 1'b0;
            r_trig_d      <= 1'b0;
            r_v1          <= 1'b0;
            r_v2          <= 1'b0;
            r_scaled      <= '0;
            r_dac_out     <= '0;
            r_dac_clk     <= 1'b0;
            r_stb_cnt     <= '0;
            r_burst_done  <= 1'b0;
        end else begin
            r_trig_d     <= trigger;
            r_burst_done <= 1'b0;

            case (r_state)
                c_IDLE: begin
                    r_acc       <= '0;
                    r_div       <= '0;
                    r_burst_cnt <= '0;
                    if (enable && r_table_valid) begin
                        if (!mode) begin
                            r_state <= c_RUN_CONT;
                        end else if (w_trig_rise && (burst_cycles != '0)) begin
                            r_state <= c_RUN_BURST;
                        end
                    end
                end
                default: begin
                    if (w_abort || w_burst_last) begin
                        r_state      <= c_IDLE;
                        r_acc        <= '0;
                        r_div        <= '0;
                        r_burst_cnt  <= '0;
                        r_burst_done <= !w_abort;
                    end else begin
                        if (w_tick) begin
                            r_acc <= w_acc_sum[PHASE_W-1:0];
                        end
                        r_div <= (r_div == c_DIV_W'(CLK_DIV - 1)) ? '0 : r_div + c_DIV_W'(1);
                        if (w_wrap_tick && (r_state == c_RUN_BURST)) begin
                            r_burst_cnt <= r_burst_cnt + c_BURST_ONE;
                        end
                    end
                end
            endcase

            if (w_swap_now) begin
                r_active      <= ~r_active;
                r_bank_ready  <= 1'b0;
                r_pending     <= 1'b0;
                r_wr_ptr      <= '0;
                r_table_valid <= 1'b1;
            end else begin
                if (wr_ptr_clr) begin
                    r_wr_ptr     <= '0;
                    r_bank_ready <= 1'b0;
                end else if (w_wr_ok) begin
                    r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
                    if (&r_wr_ptr) begin
                        r_bank_ready <= 1'b1;
                    end
                end
                if (swap_req && r_bank_ready && !wr_ptr_clr) begin
                    r_pending <= 1'b1;
                end
            end

            // Samples in flight are dropped once the generator returns to idle.
            r_v1 <= w_tick;
            r_v2 <= r_v1 && w_running;
            if (r_v1) begin
                r_scaled <= w_scaled;
            end
            if (r_v2 && w_running) begin
                r_dac_out <= w_sat;
            end

            if (!w_running) begin
                r_dac_clk <= 1'b0;
                r_stb_cnt <= '0;
            end else if (r_v2) begin
                r_dac_clk <= 1'b0;
                r_stb_cnt <= c_STB_W'(c_HALF);
            end else if (r_stb_cnt != '0) begin
                r_stb_cnt <= r_stb_cnt - c_STB_W'(1);
                if (r_stb_cnt == c_STB_W'(1)) begin
                    r_dac_clk <= 1'b1;
                end
            end
        end
    end

    assign dac_clk     = r_dac_clk;
    assign dac_out     = r_dac_out;
    assign bank_ready  = r_bank_ready;
    assign active_bank = r_active;
    assign busy        = w_running;
    assign burst_done  = r_burst_done;

endmodule
`default_nettype wire
